// File: rtl/branch_pkg.sv
// Shared encodings for the branch unit: BrOp fields, funct3 codes and
// 2-bit BHT counter states, plus the saturating counter step.
package branch_pkg;

    localparam int         BROP_JUMP_BIT  = 4;
    localparam logic [1:0] BROP_KIND_NONE = 2'b00;
    localparam logic [1:0] BROP_KIND_COND = 2'b01;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef logic [1:0] bht_state_t;

    localparam bht_state_t BHT_SNT   = 2'b00;
    localparam bht_state_t BHT_WNT   = 2'b01;
    localparam bht_state_t BHT_WT    = 2'b10;
    localparam bht_state_t BHT_ST    = 2'b11;
    localparam bht_state_t BHT_RESET = BHT_WNT;

    // One step of the 2-bit saturating counter toward the resolved outcome.
    function automatic bht_state_t bht_next(input bht_state_t state, input logic taken);
        bht_state_t nxt;
        nxt = state;
        if (taken) begin
            if (state != BHT_ST) nxt = state + 2'd1;
        end else begin
            if (state != BHT_SNT) nxt = state - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition resolver: decodes BrOp and compares the
// two register operands for the RV32 conditional branch funct3 codes.
module branch_cond_eval
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] RURs1,
    input  logic [XLEN-1:0] RURs2,
    input  logic [4:0]      BrOp,
    output logic            taken,
    output logic            is_cond
);

    logic       is_eq;
    logic       is_lt_s;
    logic       is_lt_u;
    logic [2:0] funct3;

    assign is_eq   = (RURs1 == RURs2);
    assign is_lt_s = ($signed(RURs1) < $signed(RURs2));
    assign is_lt_u = (RURs1 < RURs2);
    assign funct3  = BrOp[2:0];

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        taken   = 1'b0;
        is_cond = 1'b0;
        if (!BrOp[BROP_JUMP_BIT] && (BrOp[4:3] == BROP_KIND_COND)) begin
            is_cond = 1'b1;
            case (funct3)
                F3_BEQ:  taken = is_eq;
                F3_BNE:  taken = !is_eq;
                F3_BLT:  taken = is_lt_s;
                F3_BGE:  taken = !is_lt_s;
                F3_BLTU: taken = is_lt_u;
                F3_BGEU: taken = !is_lt_u;
                // 010/011 are reserved: behave as no branch at all.
                default: is_cond = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// EX-stage branch resolution with a PC-indexed 2-bit BHT for fetch prediction,
// misprediction redirect and saturating branch/mispredict statistics.
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int BHT_IDX_BITS = 6,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  IF_PC,
    output logic             PredTaken,
    input  logic             ExValid,
    input  logic [XLEN-1:0]  ExPC,
    input  logic [XLEN-1:0]  RURs1,
    input  logic [XLEN-1:0]  RURs2,
    input  logic [4:0]       BrOp,
    input  logic             PredTakenEx,
    output logic             NextPCSrc,
    output logic             Redirect,
    output logic [CNT_W-1:0] BranchCnt,
    output logic [CNT_W-1:0] MispredCnt
);

    localparam int               BHT_ENTRIES = 1 << BHT_IDX_BITS;
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    logic                    ex_taken;
    logic                    ex_is_cond;
    logic                    ex_jump;
    logic                    cond_resolved;
    logic                    mispredict;
    logic [BHT_IDX_BITS-1:0] if_idx;
    logic [BHT_IDX_BITS-1:0] ex_idx;

    bht_state_t       bht_q [BHT_ENTRIES];
    bht_state_t       bht_d [BHT_ENTRIES];
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    // Word-aligned PCs: bits [1:0] and everything above the index are not used.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{IF_PC[XLEN-1:BHT_IDX_BITS+2], IF_PC[1:0],
                              ExPC[XLEN-1:BHT_IDX_BITS+2], ExPC[1:0]};

    branch_cond_eval #(
        .XLEN (XLEN)
    ) u_cond_eval (
        .RURs1   (RURs1),
        .RURs2   (RURs2),
        .BrOp    (BrOp),
        .taken   (ex_taken),
        .is_cond (ex_is_cond)
    );

    assign if_idx        = IF_PC[BHT_IDX_BITS+1:2];
    assign ex_idx        = ExPC[BHT_IDX_BITS+1:2];
    assign ex_jump       = BrOp[BROP_JUMP_BIT];
    assign cond_resolved = ExValid & ex_is_cond;
    assign mispredict    = cond_resolved & (ex_taken != PredTakenEx);

    assign NextPCSrc  = ExValid & (ex_jump | ex_taken);
    assign Redirect   = (ExValid & ex_jump) | mispredict;
    assign PredTaken  = bht_q[if_idx][1];
    assign BranchCnt  = branch_cnt_q;
    assign MispredCnt = mispred_cnt_q;

    always_comb begin
        bht_d = bht_q;
        if (cond_resolved) begin
            bht_d[ex_idx] = bht_next(bht_q[ex_idx], ex_taken);
        end
    end

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (cond_resolved && !(&branch_cnt_q)) begin
            branch_cnt_d = branch_cnt_q + CNT_ONE;
        end
        if (mispredict && !(&mispred_cnt_q)) begin
            mispred_cnt_d = mispred_cnt_q + CNT_ONE;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the BHT is a flop array, so one reset cycle restores every entry to weak-NT.
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= BHT_RESET;
            end
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            bht_q         <= bht_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: hand-computed outcomes, BHT counter
// walks, aliasing, saturation of narrow statistics counters and mid-stream reset.
module tb_branch_predict_unit;

    logic        clk;
    logic        rst;
    logic [31:0] IF_PC;
    logic        PredTaken;
    logic        ExValid;
    logic [31:0] ExPC;
    logic [31:0] RURs1;
    logic [31:0] RURs2;
    logic [4:0]  BrOp;
    logic        PredTakenEx;
    logic        NextPCSrc;
    logic        Redirect;
    logic [31:0] BranchCnt;
    logic [31:0] MispredCnt;

    // Second instance with 2-bit statistics counters, driven by the same inputs.
    logic        sat_pred_taken;
    logic        sat_next_pc_src;
    logic        sat_redirect;
    logic [1:0]  sat_branch_cnt;
    logic [1:0]  sat_mispred_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    branch_predict_unit dut (
        .clk         (clk),
        .rst         (rst),
        .IF_PC       (IF_PC),
        .PredTaken   (PredTaken),
        .ExValid     (ExValid),
        .ExPC        (ExPC),
        .RURs1       (RURs1),
        .RURs2       (RURs2),
        .BrOp        (BrOp),
        .PredTakenEx (PredTakenEx),
        .NextPCSrc   (NextPCSrc),
        .Redirect    (Redirect),
        .BranchCnt   (BranchCnt),
        .MispredCnt  (MispredCnt)
    );

    branch_predict_unit #(
        .CNT_W (2)
    ) dut_sat (
        .clk         (clk),
        .rst         (rst),
        .IF_PC       (IF_PC),
        .PredTaken   (sat_pred_taken),
        .ExValid     (ExValid),
        .ExPC        (ExPC),
        .RURs1       (RURs1),
        .RURs2       (RURs2),
        .BrOp        (BrOp),
        .PredTakenEx (PredTakenEx),
        .NextPCSrc   (sat_next_pc_src),
        .Redirect    (sat_redirect),
        .BranchCnt   (sat_branch_cnt),
        .MispredCnt  (sat_mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Step past the next rising edge and let registered state settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_set(input logic valid, input logic [4:0] op, input logic [31:0] pc,
                          input logic [31:0] a, input logic [31:0] b, input logic pred);
        ExValid     = valid;
        BrOp        = op;
        ExPC        = pc;
        RURs1       = a;
        RURs2       = b;
        PredTakenEx = pred;
        #1;
    endtask

    task automatic ex_idle();
        ExValid     = 1'b0;
        BrOp        = 5'b00000;
        PredTakenEx = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        IF_PC = 32'h40;
        ex_set(1'b0, 5'b00000, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        #1;

        // 1: reset state
        chk("rst_pred_taken", {31'b0, PredTaken}, 32'd0);
        chk("rst_branch_cnt", BranchCnt, 32'd0);
        chk("rst_mispred_cnt", MispredCnt, 32'd0);
        chk("rst_next_pc_src", {31'b0, NextPCSrc}, 32'd0);
        chk("rst_redirect", {31'b0, Redirect}, 32'd0);

        // 2: BEQ taken, predicted not-taken; entry 0 goes 01 -> 10
        IF_PC = 32'h100;
        ex_set(1'b1, 5'b01000, 32'h100, 32'd10, 32'd10, 1'b0);
        chk("beq_next_pc_src", {31'b0, NextPCSrc}, 32'd1);
        chk("beq_redirect", {31'b0, Redirect}, 32'd1);
        chk("beq_pred_before", {31'b0, PredTaken}, 32'd0);
        tick();
        ex_idle();
        chk("beq_pred_after", {31'b0, PredTaken}, 32'd1);
        chk("beq_branch_cnt", BranchCnt, 32'd1);
        chk("beq_mispred_cnt", MispredCnt, 32'd1);

        // 3: three more taken (predicted taken) -> 11, saturating
        ex_set(1'b1, 5'b01000, 32'h100, 32'd10, 32'd10, 1'b1);
        chk("beq2_redirect", {31'b0, Redirect}, 32'd0);
        tick();
        chk("beq2_pred", {31'b0, PredTaken}, 32'd1);
        tick();
        chk("beq3_pred", {31'b0, PredTaken}, 32'd1);
        tick();
        chk("beq4_pred", {31'b0, PredTaken}, 32'd1);
        chk("beq4_branch_cnt", BranchCnt, 32'd4);
        chk("beq4_mispred_cnt", MispredCnt, 32'd1);
        // BNE with equal operands: not taken, predicted taken -> 10
        ex_set(1'b1, 5'b01001, 32'h100, 32'd7, 32'd7, 1'b1);
        chk("bne_next_pc_src", {31'b0, NextPCSrc}, 32'd0);
        chk("bne_redirect", {31'b0, Redirect}, 32'd1);
        tick();
        chk("bne_pred", {31'b0, PredTaken}, 32'd1);
        chk("bne_branch_cnt", BranchCnt, 32'd5);
        chk("bne_mispred_cnt", MispredCnt, 32'd2);
        chk("sat_branch_cnt_5", {30'b0, sat_branch_cnt}, 32'd3);
        chk("sat_mispred_cnt_2", {30'b0, sat_mispred_cnt}, 32'd2);
        // Second not-taken: 10 -> 01, prediction flips
        tick();
        ex_idle();
        chk("bne2_pred", {31'b0, PredTaken}, 32'd0);
        chk("bne2_branch_cnt", BranchCnt, 32'd6);
        chk("bne2_mispred_cnt", MispredCnt, 32'd3);
        chk("sat_mispred_cnt_3", {30'b0, sat_mispred_cnt}, 32'd3);

        // 4: signed vs unsigned compares on -1 vs 1, entries 1 and 2
        IF_PC = 32'h104;
        ex_set(1'b1, 5'b01100, 32'h104, 32'hFFFF_FFFF, 32'd1, 1'b1);
        chk("blt_next_pc_src", {31'b0, NextPCSrc}, 32'd1);
        chk("blt_redirect", {31'b0, Redirect}, 32'd0);
        tick();
        chk("blt_pred", {31'b0, PredTaken}, 32'd1);
        ex_set(1'b1, 5'b01110, 32'h104, 32'hFFFF_FFFF, 32'd1, 1'b0);
        chk("bltu_next_pc_src", {31'b0, NextPCSrc}, 32'd0);
        chk("bltu_redirect", {31'b0, Redirect}, 32'd0);
        tick();
        chk("bltu_pred", {31'b0, PredTaken}, 32'd0);
        IF_PC = 32'h108;
        ex_set(1'b1, 5'b01111, 32'h108, 32'hFFFF_FFFF, 32'd1, 1'b1);
        chk("bgeu_next_pc_src", {31'b0, NextPCSrc}, 32'd1);
        tick();
        chk("bgeu_pred", {31'b0, PredTaken}, 32'd1);
        ex_set(1'b1, 5'b01101, 32'h108, 32'hFFFF_FFFF, 32'd1, 1'b1);
        chk("bge_next_pc_src", {31'b0, NextPCSrc}, 32'd0);
        chk("bge_redirect", {31'b0, Redirect}, 32'd1);
        tick();
        chk("bge_pred", {31'b0, PredTaken}, 32'd0);
        chk("cmp_branch_cnt", BranchCnt, 32'd10);
        chk("cmp_mispred_cnt", MispredCnt, 32'd4);
        // Reserved funct3 010: no outcome, no redirect, no state change
        IF_PC = 32'h100;
        ex_set(1'b1, 5'b01010, 32'h100, 32'd3, 32'd3, 1'b1);
        chk("f3_010_next_pc_src", {31'b0, NextPCSrc}, 32'd0);
        chk("f3_010_redirect", {31'b0, Redirect}, 32'd0);
        tick();
        chk("f3_010_branch_cnt", BranchCnt, 32'd10);
        chk("f3_010_mispred_cnt", MispredCnt, 32'd4);
        // Entry 0 must still be 01: one taken lifts it to 10
        ex_set(1'b1, 5'b01000, 32'h100, 32'd3, 32'd3, 1'b0);
        tick();
        chk("f3_010_entry_kept", {31'b0, PredTaken}, 32'd1);
        chk("post_branch_cnt", BranchCnt, 32'd11);
        chk("post_mispred_cnt", MispredCnt, 32'd5);

        // 5: JAL redirects but leaves BHT and counters alone
        ex_set(1'b1, 5'b10000, 32'h100, 32'd1, 32'd2, 1'b0);
        chk("jal_next_pc_src", {31'b0, NextPCSrc}, 32'd1);
        chk("jal_redirect", {31'b0, Redirect}, 32'd1);
        tick();
        chk("jal_pred", {31'b0, PredTaken}, 32'd1);
        chk("jal_branch_cnt", BranchCnt, 32'd11);
        chk("jal_mispred_cnt", MispredCnt, 32'd5);
        ex_set(1'b0, 5'b10000, 32'h100, 32'd1, 32'd2, 1'b0);
        chk("jal_inv_next_pc_src", {31'b0, NextPCSrc}, 32'd0);
        chk("jal_inv_redirect", {31'b0, Redirect}, 32'd0);
        chk("sat_branch_cnt_hold", {30'b0, sat_branch_cnt}, 32'd3);
        chk("sat_mispred_cnt_hold", {30'b0, sat_mispred_cnt}, 32'd3);
        // Invalid conditional must not update entry 0 (still 10)
        ex_set(1'b0, 5'b01001, 32'h100, 32'd1, 32'd1, 1'b0);
        tick();
        chk("inv_cond_pred", {31'b0, PredTaken}, 32'd1);
        chk("inv_cond_branch_cnt", BranchCnt, 32'd11);

        // 6b: mid-stream reset with a concurrent EX update that must be discarded
        rst = 1'b1;
        ex_set(1'b1, 5'b01000, 32'h100, 32'd4, 32'd4, 1'b0);
        chk("rst_comb_next_pc_src", {31'b0, NextPCSrc}, 32'd1);
        chk("rst_comb_redirect", {31'b0, Redirect}, 32'd1);
        tick();
        rst = 1'b0;
        ex_idle();
        chk("mid_rst_pred_e0", {31'b0, PredTaken}, 32'd0);
        chk("mid_rst_branch_cnt", BranchCnt, 32'd0);
        chk("mid_rst_mispred_cnt", MispredCnt, 32'd0);
        chk("mid_rst_sat_branch_cnt", {30'b0, sat_branch_cnt}, 32'd0);
        IF_PC = 32'h104;
        #1;
        chk("mid_rst_pred_e1", {31'b0, PredTaken}, 32'd0);

        // 6a: 0x200 reads and 0x300 writes the same entry in one cycle
        IF_PC = 32'h200;
        ex_set(1'b1, 5'b01000, 32'h300, 32'd9, 32'd9, 1'b0);
        chk("alias_pred_old", {31'b0, PredTaken}, 32'd0);
        tick();
        ex_idle();
        chk("alias_pred_new", {31'b0, PredTaken}, 32'd1);
        chk("alias_branch_cnt", BranchCnt, 32'd1);
        chk("alias_mispred_cnt", MispredCnt, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
